// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the seq_div sequential restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Width of a step counter that must reach n-1.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring division step: shift in a numerator bit, subtract if it fits.
module div_step #(
  parameter int unsigned DEN_W = 4
) (
  input  logic [DEN_W-1:0] partial_i,
  input  logic [DEN_W-1:0] den_i,
  input  logic             bit_i,
  output logic [DEN_W-1:0] partial_o,
  output logic             qbit_o
);

  logic [DEN_W:0] shifted;
  logic [DEN_W:0] diff;

  always_comb begin
    shifted = {partial_i, bit_i};
    diff    = shifted - {1'b0, den_i};
    // partial_i < den_i keeps diff inside (-2^DEN_W, 2^DEN_W), so the top bit is the borrow.
    qbit_o    = ~diff[DEN_W];
    partial_o = qbit_o ? diff[DEN_W-1:0] : shifted[DEN_W-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Define SEQ_DIV_SIGNED_EN to honour signed_mode (two's complement operands).
module seq_div
  import seq_div_pkg::*;
#(
  parameter int unsigned NUM_W = 8,
  parameter int unsigned DEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DEN_W-1:0] denominator,
  output logic             ready,
  output logic             done,
  output logic [NUM_W-1:0] quotient,
  output logic [DEN_W-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = cnt_width(NUM_W);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [DEN_W-1:0] part_q, part_d;
  logic [DEN_W-1:0] rawlo_q, rawlo_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [NUM_W-1:0] quot_q, quot_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [NUM_W-1:0] num_mag;
  logic [DEN_W-1:0] den_mag;
  logic             neg_n, neg_d;
  logic [DEN_W-1:0] step_part;
  logic             step_qbit;
  logic [NUM_W-1:0] q_mag, q_fin;
  logic [DEN_W-1:0] r_fin;

  div_step #(
    .DEN_W(DEN_W)
  ) u_step (
    .partial_i(part_q),
    .den_i    (den_q),
    .bit_i    (num_q[NUM_W-1]),
    .partial_o(step_part),
    .qbit_o   (step_qbit)
  );

`ifdef SEQ_DIV_SIGNED_EN
  always_comb begin
    neg_n   = signed_mode & numerator[NUM_W-1];
    neg_d   = signed_mode & denominator[DEN_W-1];
    num_mag = neg_n ? (~numerator + 1'b1) : numerator;
    den_mag = neg_d ? (~denominator + 1'b1) : denominator;
  end
`else
  logic unused_signed_mode;
  assign unused_signed_mode = signed_mode;

  always_comb begin
    neg_n   = 1'b0;
    neg_d   = 1'b0;
    num_mag = numerator;
    den_mag = denominator;
  end
`endif

  // The numerator register shifts out dividend bits and shifts in quotient bits.
  always_comb begin
    q_mag = {num_q[NUM_W-2:0], step_qbit};
    q_fin = negq_q ? (~q_mag + 1'b1) : q_mag;
    r_fin = negr_q ? (~step_part + 1'b1) : step_part;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    den_d   = den_q;
    part_d  = part_q;
    rawlo_d = rawlo_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
          num_d   = num_mag;
          den_d   = den_mag;
          part_d  = '0;
          rawlo_d = numerator[DEN_W-1:0];
          negq_d  = neg_n ^ neg_d;
          negr_d  = neg_n;
        end
      end
      StRun: begin
        if (den_q == '0) begin
          state_d = StDone;
          quot_d  = '1;
          rem_d   = rawlo_q;
          dbz_d   = 1'b1;
        end else begin
          num_d  = q_mag;
          part_d = step_part;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CntW'(NUM_W - 1)) begin
            state_d = StDone;
            quot_d  = q_fin;
            rem_d   = r_fin;
            dbz_d   = 1'b0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      num_q   <= '0;
      den_q   <= '0;
      part_q  <= '0;
      rawlo_q <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      den_q   <= den_d;
      part_q  <= part_d;
      rawlo_q <= rawlo_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ready       = (state_q == StIdle);
  assign done        = (state_q == StDone);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter NUM_W, default 8, numerator and quotient width (legal range 2..32).
REQ-002 SHALL have parameter DEN_W, default 4, denominator and remainder width (legal range 2..NUM_W).
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to begin a division; accepted only when ready=1.
REQ-006 SHALL have port signed_mode, input, 1, operands are two's complement when 1; sampled with start.
REQ-007 SHALL have port numerator, input, NUM_W, dividend; sampled on acceptance.
REQ-008 SHALL have port denominator, input, DEN_W, divisor; sampled on acceptance.
REQ-009 SHALL have port ready, output, 1, high only in IDLE.
REQ-010 SHALL have port done, output, 1, single-cycle pulse marking valid results.
REQ-011 SHALL have port quotient, output, NUM_W, registered result.
REQ-012 SHALL have port remainder, output, DEN_W, registered result.
REQ-013 SHALL have port div_by_zero, output, 1, registered flag, valid with done.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL accept on the edge where start=1 and ready=1 (edge E0): capture operands, clear step counter, go to RUN.
REQ-016 SHALL ignore start while not in IDLE; operand changes after E0 do not affect the result.
REQ-017 SHALL perform exactly one restoring step per RUN cycle, MSB first: shift partial remainder (DEN_W+1 bits) left, bring in next numerator bit, subtract denominator if partial >= denominator and set that quotient bit.
REQ-018 SHALL perform NUM_W steps, with the last on edge E_NUM_W, loading quotient/remainder/div_by_zero and entering DONE at that edge; latency = NUM_W edges.
REQ-019 SHALL, in DONE, hold done=1 and ready=0 for exactly one cycle, then return to IDLE.
REQ-020 SHALL hold quotient, remainder and div_by_zero stable from DONE until the next E_NUM_W (or reset).
REQ-021 SHALL, on denominator=0, skip RUN: go to DONE at E1 with quotient=all ones, remainder=numerator[DEN_W-1:0], div_by_zero=1; otherwise div_by_zero=0.
REQ-022 SHALL give unsigned results satisfying numerator = quotient*denominator + remainder, remainder < denominator.

Reset
REQ-023 SHALL, with rst=1 at any edge, including mid-RUN, go to IDLE and set ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, step counter=0; rst overrides start.
REQ-024 SHALL, when rst=1 occurs mid-RUN, discard the in-flight operation without producing a done pulse.

Configuration
REQ-025 SHALL, with SEQ_DIV_SIGNED_EN defined, honour signed_mode: magnitudes taken at E0, quotient truncated toward zero, remainder sign equals numerator sign, signs restored at E_NUM_W with identical latency.
REQ-026 SHALL, for the signed case most-negative/-1, wrap quotient to the most-negative value with remainder=0.
REQ-027 SHALL, without SEQ_DIV_SIGNED_EN, keep the signed_mode port but ignore it, so all operations are unsigned.

Structure
REQ-028 SHALL place the state enum typedef (IDLE/RUN/DONE) and counter-width helper constant in package seq_div_pkg.
REQ-029 SHALL instantiate one combinational sub-module div_step for a single restoring step (partial remainder in, denominator, next bit in; partial remainder and quotient bit out).

Verification
REQ-030 SHALL verify, with defaults, start with 200/7 unsigned -> done exactly 8 edges after E0; quotient=28, remainder=4, div_by_zero=0.
REQ-031 SHALL verify 100/0 -> done 1 edge after E0; quotient=8'hFF, remainder=4'h4, div_by_zero=1.
REQ-032 SHALL verify, with SEQ_DIV_SIGNED_EN, signed_mode=1 with 8'h9C (-100) / 4'h7 -> quotient=8'hF2 (-14), remainder=4'hE (-2); the same without the macro gives 156/7 = 22 r 2.
REQ-033 SHALL verify rst pulsed on the 4th RUN cycle of 255/15 -> no done pulse, all outputs zero, ready=1 next cycle; a following 255/15 gives quotient=17, remainder=0.
REQ-034 SHALL verify start held high through RUN with changing operands -> single result for the E0 operands, next acceptance only after the DONE cycle.
REQ-035 SHALL verify NUM_W=16, DEN_W=8 with 50000/255 -> done 16 edges after E0, quotient=196, remainder=20.
